// File: rtl/prefix_adder_pipe_pkg.sv
// prefix_adder_pipe_pkg
//   Shared constant functions for the pipelined Kogge-Stone adder.
//   clog2     : prefix depth for a given operand width.
//   cut_after : whether a register slice follows a given prefix level.
//   There are no ports; the package is imported by prefix_adder_pipe.
`ifndef PREFIX_ADDER_PIPE_PKG_SV
`define PREFIX_ADDER_PIPE_PKG_SV

package prefix_adder_pipe_pkg;

  // Ceiling log2 for n >= 1 (clog2(1) = 0).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r++;
    end
    return r;
  endfunction

  // Levels are numbered from 0. A cut follows every per_stage-th level.
  // The last level always gets one, so the sum stage starts from registers.
  // Pipeline latency is therefore ceil(levels / per_stage) + 1.
  function automatic bit cut_after(input int lvl, input int levels, input int per_stage);
    return (((lvl + 1) % per_stage) == 0) || (lvl == levels - 1);
  endfunction

endpackage

`endif

// File: rtl/prefix_adder_pipe_pg_combine_cell.sv
// pg_combine_inv / pg_combine_cell
//   Group propagate/generate combine for one prefix node.
//   The upper group (hi) is merged with the adjacent lower group (lo).
//   pg_combine_inv is the inverting AOI/NAND form.
//   pg_combine_cell restores true polarity so prefix levels can be chained
//   without tracking alternating polarity.
//   Ports (both modules):
//     g_hi_i, p_hi_i : generate/propagate of the upper group
//     g_lo_i, p_lo_i : generate/propagate of the lower group
//     pg_combine_inv  : g_n_o = ~(Gu | Pu&Gl), p_n_o = ~(Pu & Pl)
//     pg_combine_cell : g_o   =   Gu | Pu&Gl,  p_o   =   Pu & Pl
`ifndef PREFIX_ADDER_PIPE_PG_COMBINE_CELL_SV
`define PREFIX_ADDER_PIPE_PG_COMBINE_CELL_SV

module pg_combine_inv (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_n_o,
  output logic p_n_o
);
  assign g_n_o = ~(g_hi_i | (p_hi_i & g_lo_i));
  assign p_n_o = ~(p_hi_i & p_lo_i);
endmodule

module pg_combine_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);
  logic g_n;
  logic p_n;

  pg_combine_inv u_inv (
    .g_hi_i (g_hi_i),
    .p_hi_i (p_hi_i),
    .g_lo_i (g_lo_i),
    .p_lo_i (p_lo_i),
    .g_n_o  (g_n),
    .p_n_o  (p_n)
  );

  assign g_o = ~g_n;
  assign p_o = ~p_n;
endmodule

`endif

// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe
//   Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake.
//   A register slice follows every STAGE_LEVELS prefix levels, and one
//   follows the final level. A registered sum stage drives the outputs.
//   Latency is ceil(clog2(WIDTH)/STAGE_LEVELS) + 1 cycles.
//   The whole pipeline stalls together whenever the output is held.
//   Ports:
//     clk, rst            : rising-edge clock, synchronous active-high reset
//     in_valid / in_ready : operand beat handshake (in_ready = pipeline enable)
//     a, b, cin, sub      : operands; sub=1 computes a + ~b + 1, ignoring cin
//     out_valid/out_ready : result beat handshake
//     sum, cout, ovf      : result, carry out (not-borrow for sub), signed overflow
`ifndef PREFIX_ADDER_PIPE_SV
`define PREFIX_ADDER_PIPE_SV

module prefix_adder_pipe
  import prefix_adder_pipe_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STAGE_LEVELS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int L = clog2(WIDTH);

  // Every stage advances together. It only holds while a result waits.
  logic en;
  logic out_valid_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Stage 0: bit-level p/g. Vector index j holds bit position j-1.
  // Index 0 is the carry-in, treated as a pure generate (p = 0).
  // So after the prefix tree, G at index j is carry(j-1).
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_bits;
  logic             c0;
  logic [WIDTH:0]   g_init;
  logic [WIDTH:0]   p_init;

  assign b_eff  = sub ? ~b : b;
  assign c0     = sub ? 1'b1 : cin;
  assign p_bits = a ^ b_eff;
  assign g_init = {a & b_eff, c0};
  assign p_init = {p_bits, 1'b0};

  genvar gi;
  for (gi = 0; gi < L; gi++) begin : g_lvl
    localparam int DIST = 1 << gi;

    logic [WIDTH:0]   g_src;
    logic [WIDTH:0]   p_src;
    logic [WIDTH:0]   g_d;
    logic [WIDTH:0]   p_d;
    logic [WIDTH:0]   g_nxt;
    logic [WIDTH:0]   p_nxt;
    logic [WIDTH-1:0] pb_src;
    logic [WIDTH-1:0] pb_nxt;
    logic             v_src;
    logic             v_nxt;

    if (gi == 0) begin : g_from_in
      assign g_src  = g_init;
      assign p_src  = p_init;
      assign pb_src = p_bits;
      assign v_src  = in_valid;
    end else begin : g_from_prev
      assign g_src  = g_lvl[gi-1].g_nxt;
      assign p_src  = g_lvl[gi-1].p_nxt;
      assign pb_src = g_lvl[gi-1].pb_nxt;
      assign v_src  = g_lvl[gi-1].v_nxt;
    end

    // Nodes whose lower partner would fall below the carry-in position
    // already span down to it and just pass through.
    for (genvar gj = 0; gj <= WIDTH; gj++) begin : g_node
      if (gj >= DIST) begin : g_cell
        pg_combine_cell u_cell (
          .g_hi_i (g_src[gj]),
          .p_hi_i (p_src[gj]),
          .g_lo_i (g_src[gj-DIST]),
          .p_lo_i (p_src[gj-DIST]),
          .g_o    (g_d[gj]),
          .p_o    (p_d[gj])
        );
      end else begin : g_buf
        assign g_d[gj] = g_src[gj];
        assign p_d[gj] = p_src[gj];
      end
    end

    if (cut_after(gi, L, STAGE_LEVELS)) begin : g_cut
      logic [WIDTH:0]   g_q;
      logic [WIDTH:0]   p_q;
      logic [WIDTH-1:0] pb_q;
      logic             v_q;

      // Only the valid bit needs reset; data behind a clear valid is ignored.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (en) begin
          v_q  <= v_src;
          g_q  <= g_d;
          p_q  <= p_d;
          pb_q <= pb_src;
        end
      end

      assign g_nxt  = g_q;
      assign p_nxt  = p_q;
      assign pb_nxt = pb_q;
      assign v_nxt  = v_q;
    end else begin : g_comb
      assign g_nxt  = g_d;
      assign p_nxt  = p_d;
      assign pb_nxt = pb_src;
      assign v_nxt  = v_src;
    end
  end

  // Sum stage. G[WIDTH] spans bits WIDTH-1..0 at least. Folding in the
  // carry-in once more gives carry(MSB). If G[WIDTH] already included it,
  // P[WIDTH] is 0 and the extra term has no effect.
  logic [WIDTH:0]   g_fin;
  logic [WIDTH:0]   p_fin;
  logic [WIDTH-1:0] pb_fin;
  logic             v_fin;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             unused_p_fin;

  assign g_fin  = g_lvl[L-1].g_nxt;
  assign p_fin  = g_lvl[L-1].p_nxt;
  assign pb_fin = g_lvl[L-1].pb_nxt;
  assign v_fin  = g_lvl[L-1].v_nxt;

  assign sum_d  = pb_fin ^ g_fin[WIDTH-1:0];
  assign cout_d = g_fin[WIDTH] | (p_fin[WIDTH] & g_fin[0]);
  // g_fin[WIDTH-1] is the carry into the MSB.
  assign ovf_d  = g_fin[WIDTH-1] ^ cout_d;

  // Only the topmost group propagate is needed by the sum stage.
  assign unused_p_fin = ^p_fin[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= v_fin;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

`endif

// File: tb/tb_prefix_adder_pipe.sv
// tb_prefix_adder_pipe
//   Main instance: WIDTH=32, STAGE_LEVELS=2. It gets directed vectors,
//   back-to-back streaming, a backpressure burst, a reset with beats in
//   flight and a random stream.
//   Two sweep instances (13/1 and 64/3) each run 1000 random beats with
//   random backpressure. Results are scored against an arithmetic model.
module tb_prefix_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain-arithmetic reference: {cout, ovf, sum} for a w-bit add/sub.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] beff;
    logic [63:0] s;
    logic [64:0] full;
    logic        c;
    logic        co;
    logic        ov;
    mask = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    beff = (sub ? ~b : b) & mask;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, am} + {1'b0, beff} + {64'd0, c};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == beff[w-1]) && (s[w-1] != am[w-1]);
    return {co, ov, s};
  endfunction

  // ---------------- main instance ----------------
  logic        rst0 = 1'b1;
  logic        in_valid0 = 1'b0;
  logic        in_ready0;
  logic [31:0] a0 = '0;
  logic [31:0] b0 = '0;
  logic        cin0 = 1'b0;
  logic        sub0 = 1'b0;
  logic        out_valid0;
  logic        out_ready0 = 1'b0;
  logic [31:0] sum0;
  logic        cout0;
  logic        ovf0;
  logic        acc0 = 1'b0;

  prefix_adder_pipe #(.WIDTH(32), .STAGE_LEVELS(2)) u_dut (
    .clk       (clk),
    .rst       (rst0),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .a         (a0),
    .b         (b0),
    .cin       (cin0),
    .sub       (sub0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .sum       (sum0),
    .cout      (cout0),
    .ovf       (ovf0)
  );

  logic [65:0] q0[$];
  logic        hold0 = 1'b0;
  logic [65:0] held0;

  always @(negedge clk) begin
    logic [65:0] obs;
    obs = {cout0, ovf0, 64'(sum0)};
    if (rst0) begin
      q0.delete();
      hold0 = 1'b0;
    end else begin
      if (hold0) begin
        chk("d0_hold_valid", {65'd0, out_valid0}, 66'd1);
        chk("d0_hold_data", obs, held0);
      end
      if (out_valid0 && out_ready0) begin
        if (q0.size() == 0) begin
          chk("d0_spurious_result", {65'd0, out_valid0}, 66'd0);
        end else begin
          logic [65:0] exp;
          exp = q0.pop_front();
          chk("d0_result", obs, exp);
          $display("[TB] d0 result sum=%08h cout=%b ovf=%b", sum0, cout0, ovf0);
        end
      end
      hold0 = out_valid0 && !out_ready0;
      held0 = obs;
      if (in_valid0 && in_ready0) begin
        q0.push_back(ref_add(32, 64'(a0), 64'(b0), cin0, sub0));
      end
    end
  end

  // Samples acceptance just before the edge, then moves to 1 after it.
  task automatic step0();
    @(negedge clk);
    acc0 = in_valid0 && in_ready0;
    @(posedge clk);
    #1;
  endtask

  task automatic new_beat0();
    a0   = $urandom();
    b0   = ($urandom_range(7) == 0) ? ~a0 : $urandom();
    cin0 = 1'($urandom_range(1));
    sub0 = 1'($urandom_range(1));
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic s, input logic [33:0] exp_v);
    int n;
    a0 = a; b0 = b; cin0 = ci; sub0 = s;
    in_valid0  = 1'b1;
    out_ready0 = 1'b1;
    step0();
    in_valid0 = 1'b0;
    n = 1;
    while (!out_valid0 && n < 20) begin
      step0();
      n++;
    end
    chk({tag, "_latency"}, 66'(n), 66'd4);
    chk(tag, {32'd0, cout0, ovf0, sum0}, {32'd0, exp_v});
    step0();
  endtask

  // Random valid/ready stream on the main instance; the source holds stalled beats.
  task automatic run_random0(input int beats);
    int sent;
    int issued;
    int cyc;
    sent = 0; issued = 0; cyc = 0;
    acc0 = 1'b0; in_valid0 = 1'b0;
    while (sent < beats && cyc < 20000) begin
      if (acc0 || !in_valid0) begin
        if (issued < beats && $urandom_range(3) != 0) begin
          new_beat0();
          issued++;
          in_valid0 = 1'b1;
        end else begin
          in_valid0 = 1'b0;
        end
      end
      out_ready0 = ($urandom_range(3) != 0);
      step0();
      cyc++;
      if (acc0) sent++;
    end
    chk("d0_random_sent", 66'(sent), 66'(beats));
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    repeat (10) step0();
    chk("d0_random_drain", 66'(q0.size()), 66'd0);
  endtask

  // ---------------- parameter sweep instances ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int W = (gi == 0) ? 13 : 64;
    localparam int S = (gi == 0) ? 1 : 3;

    logic         rst_s = 1'b1;
    logic         in_valid_s = 1'b0;
    logic         in_ready_s;
    logic [W-1:0] a_s = '0;
    logic [W-1:0] b_s = '0;
    logic         cin_s = 1'b0;
    logic         sub_s = 1'b0;
    logic         out_valid_s;
    logic         out_ready_s = 1'b0;
    logic [W-1:0] sum_s;
    logic         cout_s;
    logic         ovf_s;
    logic         acc_s = 1'b0;
    bit           done = 1'b0;
    logic [65:0]  q_s[$];
    logic         hold_s = 1'b0;
    logic [65:0]  held_s;

    prefix_adder_pipe #(.WIDTH(W), .STAGE_LEVELS(S)) u_dut (
      .clk       (clk),
      .rst       (rst_s),
      .in_valid  (in_valid_s),
      .in_ready  (in_ready_s),
      .a         (a_s),
      .b         (b_s),
      .cin       (cin_s),
      .sub       (sub_s),
      .out_valid (out_valid_s),
      .out_ready (out_ready_s),
      .sum       (sum_s),
      .cout      (cout_s),
      .ovf       (ovf_s)
    );

    always @(negedge clk) begin
      logic [65:0] obs;
      obs = {cout_s, ovf_s, 64'(sum_s)};
      if (rst_s) begin
        q_s.delete();
        hold_s = 1'b0;
      end else begin
        if (hold_s) begin
          chk("sw_hold_data", obs, held_s);
        end
        if (out_valid_s && out_ready_s) begin
          if (q_s.size() == 0) begin
            chk("sw_spurious_result", {65'd0, out_valid_s}, 66'd0);
          end else begin
            logic [65:0] exp;
            exp = q_s.pop_front();
            chk($sformatf("sw%0d_result", W), obs, exp);
            $display("[TB] w%0d result sum=%0h cout=%b ovf=%b", W, sum_s, cout_s, ovf_s);
          end
        end
        hold_s = out_valid_s && !out_ready_s;
        held_s = obs;
        if (in_valid_s && in_ready_s) begin
          q_s.push_back(ref_add(W, 64'(a_s), 64'(b_s), cin_s, sub_s));
        end
      end
    end

    initial begin
      int sent;
      int issued;
      int cyc;
      sent = 0; issued = 0; cyc = 0;
      repeat (3) @(posedge clk);
      #1 rst_s = 1'b0;
      while (sent < 1000 && cyc < 20000) begin
        if (acc_s || !in_valid_s) begin
          if (issued < 1000 && $urandom_range(3) != 0) begin
            a_s   = W'({$urandom(), $urandom()});
            b_s   = ($urandom_range(7) == 0) ? ~a_s : W'({$urandom(), $urandom()});
            cin_s = 1'($urandom_range(1));
            sub_s = 1'($urandom_range(1));
            issued++;
            in_valid_s = 1'b1;
          end else begin
            in_valid_s = 1'b0;
          end
        end
        out_ready_s = ($urandom_range(3) != 0);
        @(negedge clk);
        acc_s = in_valid_s && in_ready_s;
        @(posedge clk);
        #1;
        cyc++;
        if (acc_s) sent++;
      end
      chk($sformatf("sw%0d_sent", W), 66'(sent), 66'd1000);
      in_valid_s  = 1'b0;
      out_ready_s = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk($sformatf("sw%0d_drain", W), 66'(q_s.size()), 66'd0);
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int          stall_hits;
    int          vcnt;
    int          issued;
    int          sent;
    int          wait_cyc;
    logic [13:0] vmask;
    logic [13:0] vexp;

    // Reset state
    repeat (3) step0();
    chk("rst_outputs", {31'd0, out_valid0, cout0, ovf0, sum0}, 66'd0);
    rst0 = 1'b0;
    step0();
    chk("rst_in_ready", {65'd0, in_ready0}, 66'd1);
    chk("idle_out_valid", {65'd0, out_valid0}, 66'd0);

    // Directed vectors; cin=1 on the last one must be ignored for sub
    directed("carry_chain", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
    directed("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
    directed("sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    directed("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});

    // 8 back-to-back beats: out_valid after edges 4..11 of the burst
    out_ready0 = 1'b1;
    vmask = '0;
    for (int i = 0; i < 14; i++) begin
      vexp[i] = (i + 1 >= 4) && (i + 1 <= 11);
      if (i < 8) begin
        new_beat0();
        in_valid0 = 1'b1;
      end else begin
        in_valid0 = 1'b0;
      end
      step0();
      vmask[i] = out_valid0;
    end
    chk("b2b_valid_pattern", 66'(vmask), 66'(vexp));

    // Burst with out_ready low for 3 cycles while results are waiting
    acc0 = 1'b0; in_valid0 = 1'b0;
    issued = 0; sent = 0; stall_hits = 0;
    for (int c = 0; c < 60 && sent < 10; c++) begin
      if (acc0 || !in_valid0) begin
        if (issued < 10) begin
          new_beat0();
          issued++;
          in_valid0 = 1'b1;
        end else begin
          in_valid0 = 1'b0;
        end
      end
      out_ready0 = !(c >= 6 && c < 9);
      #1;
      if (!out_ready0) begin
        chk("bp_in_ready", {65'd0, in_ready0}, {65'd0, !out_valid0});
        if (out_valid0) stall_hits++;
      end
      step0();
      if (acc0) sent++;
    end
    chk("bp_stall_cycles", 66'(stall_hits), 66'd3);
    chk("bp_sent", 66'(sent), 66'd10);
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    repeat (8) step0();
    chk("bp_drain", 66'(q0.size()), 66'd0);

    // Reset with 3 beats in flight: none of them may ever appear
    out_ready0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_beat0();
      in_valid0 = 1'b1;
      step0();
    end
    in_valid0 = 1'b0;
    rst0 = 1'b1;
    step0();
    chk("rst_flight_valid", {65'd0, out_valid0}, 66'd0);
    rst0 = 1'b0;
    out_ready0 = 1'b0;
    step0();
    chk("rst_flight_in_ready", {65'd0, in_ready0}, 66'd1);
    out_ready0 = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step0();
      if (out_valid0) vcnt++;
    end
    chk("rst_flight_never", 66'(vcnt), 66'd0);

    // Random stream with random backpressure
    run_random0(300);

    // Wait for the sweep instances
    wait_cyc = 0;
    while (!(g_sweep[0].done && g_sweep[1].done) && wait_cyc < 30000) begin
      @(posedge clk);
      wait_cyc++;
    end
    chk("sweep_done", {64'd0, g_sweep[1].done, g_sweep[0].done}, 66'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
